// File: rtl/fifo_pkg.sv
// Shared state encodings for the FIFO word packer; the bench imports these for state checks.
package fifo_pkg;
  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_DRAIN = 2'd1,
    S_EMIT  = 2'd2
  } state_t;
endpackage

// File: rtl/fifo_word_packer.sv
// Read-side FIFO consumer: pops IN_WIDTH entries, packs RATIO of them per output word,
// and emits a keep-marked partial word when flushed.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input  logic                      rd_clk,
  input  logic                      rst_n,
  input  logic                      fifo_empty,
  input  logic [IN_WIDTH-1:0]       fifo_data_out,
  output logic                      fifo_rd_en,
  input  logic                      flush,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [IN_WIDTH*RATIO-1:0] m_data,
  output logic [RATIO-1:0]          m_keep,
  output logic                      busy
);

  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int CW        = $clog2(RATIO + 1);
  localparam logic [CW-1:0] FULL = CW'(RATIO);

  function automatic logic [RATIO-1:0] keep_mask(input logic [CW-1:0] n);
    logic [RATIO-1:0] k;
    k = '0;
    for (int i = 0; i < RATIO; i++)
      if (i < int'(n)) k[i] = 1'b1;
    return k;
  endfunction

  function automatic logic [OUT_WIDTH-1:0] lane_mask(input logic [RATIO-1:0] k);
    logic [OUT_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < RATIO; i++)
      m[i*IN_WIDTH +: IN_WIDTH] = {IN_WIDTH{k[i]}};
    return m;
  endfunction

  state_t               state;
  logic [CW-1:0]        cnt;
  logic                 rd_pend;
  logic [OUT_WIDTH-1:0] asm_word;

  logic          word_ready;
  logic          xfer;
  logic [CW-1:0] cnt_eff;
  logic [CW:0]   fill_lvl;
  logic          flush_go;
  logic          flush_pend;
  logic          pop;

  assign word_ready = (cnt == FULL) || (state == S_EMIT);
  assign xfer       = word_ready && (!m_valid || m_ready);
  assign cnt_eff    = xfer ? '0 : cnt;
  assign fill_lvl   = {1'b0, cnt_eff} + {{CW{1'b0}}, rd_pend};
  assign flush_go   = (state == S_FILL) && flush && ((cnt != '0) || rd_pend);
  assign flush_pend = (state != S_FILL);

  // Gated by rst_n so no pop is requested while the packer is held in reset.
  assign fifo_rd_en = rst_n && !fifo_empty && (state == S_FILL) && !flush_go &&
                      (fill_lvl < (CW+1)'(RATIO));
  assign pop        = fifo_rd_en && !fifo_empty;
  assign busy       = (cnt != '0) || rd_pend || flush_pend || m_valid;

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FILL;
      cnt      <= '0;
      rd_pend  <= 1'b0;
      asm_word <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_keep   <= '0;
    end else begin
      rd_pend <= pop;
      cnt     <= cnt_eff + CW'(rd_pend);

      // Capture stage: the byte popped last cycle lands in lane cnt.
      for (int i = 0; i < RATIO; i++)
        if (rd_pend && (cnt == CW'(i)))
          asm_word[i*IN_WIDTH +: IN_WIDTH] <= fifo_data_out;

      // Output stage: stale lanes above cnt are zeroed on the way out.
      if (xfer) begin
        m_data  <= asm_word & lane_mask(keep_mask(cnt));
        m_keep  <= keep_mask(cnt);
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end

      case (state)
        S_FILL:  if (flush_go) state <= S_DRAIN;
        S_DRAIN: begin
          // A full word caught by the flush leaves through the normal path.
          if (!rd_pend) begin
            if (cnt_eff == '0)  state <= S_FILL;
            else if (cnt != FULL) state <= S_EMIT;
          end
        end
        S_EMIT:  if (xfer) state <= S_FILL;
        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer with a behavioural FIFO read port (1-cycle read latency).
module tb_fifo_word_packer;
  import fifo_pkg::*;

  logic        rd_clk = 1'b0;
  logic        rst_n;
  logic        fifo_empty;
  logic [7:0]  fifo_data_out = '0;
  logic        fifo_rd_en;
  logic        flush;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;

  always #5 rd_clk = ~rd_clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge rd_clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data_out <= mem[rd_ptr[5:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  fifo_word_packer #(.IN_WIDTH(8), .RATIO(4)) dut (
    .rd_clk(rd_clk), .rst_n(rst_n), .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out), .fifo_rd_en(fifo_rd_en), .flush(flush),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[5:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  waited;
    bit  seen;
    rst_n = 1'b0; flush = 1'b0; m_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_keep",  64'(m_keep),  64'd0);
    chk("rst_data",  64'(m_data),  64'd0);
    chk("rst_busy",  64'(busy),    64'd0);
    rst_n = 1'b1;
    tick();

    // 1: single full word, latency five cycles after first pop
    m_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t1_wait_valid", 64'(m_valid), 64'd0);
    end
    tick();
    chk("t1_valid", 64'(m_valid), 64'd1);
    chk("t1_data",  64'(m_data),  64'h44332211);
    chk("t1_keep",  64'(m_keep),  64'hF);
    tick();
    chk("t1_pulse", 64'(m_valid), 64'd0);
    chk("t1_busy",  64'(busy),    64'd0);

    // 2: backpressure holds word 1 and stalls pops once word 2 is assembled
    m_ready = 1'b0;
    for (int b = 1; b <= 8; b++) push(8'(b));
    for (int k = 0; k < 7; k++) tick();
    chk("t2_w1_valid", 64'(m_valid), 64'd1);
    chk("t2_w1_data",  64'(m_data),  64'h04030201);
    for (int k = 0; k < 3; k++) tick();
    chk("t2_w1_stable", 64'(m_data),     64'h04030201);
    chk("t2_cnt_full",  64'(dut.cnt),    64'd4);
    chk("t2_no_pop",    64'(fifo_rd_en), 64'd0);
    tick();
    chk("t2_no_pop2",   64'(fifo_rd_en), 64'd0);
    chk("t2_hold",      64'(m_valid),    64'd1);
    m_ready = 1'b1;
    tick();
    chk("t2_w2_valid", 64'(m_valid), 64'd1);
    chk("t2_w2_data",  64'(m_data),  64'h08070605);
    chk("t2_w2_keep",  64'(m_keep),  64'hF);
    tick();
    chk("t2_done", 64'(m_valid), 64'd0);

    // 3: flush of a two-byte partial word
    push(8'hAA); push(8'hBB);
    for (int k = 0; k < 4; k++) tick();
    chk("t3_cnt", 64'(dut.cnt), 64'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t3_drain", 64'(dut.state), 64'(S_DRAIN));
    tick();
    chk("t3_emit", 64'(dut.state), 64'(S_EMIT));
    tick();
    chk("t3_valid", 64'(m_valid), 64'd1);
    chk("t3_data",  64'(m_data),  64'h0000BBAA);
    chk("t3_keep",  64'(m_keep),  64'h3);
    chk("t3_busy_hi", 64'(busy),  64'd1);
    tick();
    chk("t3_busy_lo", 64'(busy),  64'd0);

    // 4: flush while idle is ignored
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_state", 64'(dut.state), 64'(S_FILL));
    tick();
    chk("t4_valid", 64'(m_valid), 64'd0);
    chk("t4_busy",  64'(busy),    64'd0);

    // 5: flush while byte 3 is in flight; its capture must still land
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4); push(8'hA5);
    tick(); tick(); tick();
    chk("t5_inflight", 64'(dut.rd_pend), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_no_pop_flush", 64'(rd_ptr), 64'd17);
    chk("t5_drain", 64'(dut.state), 64'(S_DRAIN));
    chk("t5_rd_en_drain", 64'(fifo_rd_en), 64'd0);
    tick();
    chk("t5_emit", 64'(dut.state), 64'(S_EMIT));
    chk("t5_rd_en_emit", 64'(fifo_rd_en), 64'd0);
    tick();
    chk("t5_valid", 64'(m_valid), 64'd1);
    chk("t5_data",  64'(m_data),  64'h00A3A2A1);
    chk("t5_keep",  64'(m_keep),  64'h7);
    chk("t5_fill",  64'(dut.state), 64'(S_FILL));
    for (int k = 0; k < 4; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick(); tick();
    chk("t5_rest_data", 64'(m_data), 64'h0000A5A4);
    chk("t5_rest_keep", 64'(m_keep), 64'h3);
    tick();

    // 6: reset mid-word drops the in-flight byte
    for (int b = 8'h61; b <= 8'h67; b++) push(8'(b));
    tick(); tick(); tick();
    chk("t6_cnt_pre", 64'(dut.cnt), 64'd2);
    chk("t6_pend_pre", 64'(dut.rd_pend), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(m_valid),    64'd0);
    chk("t6_rst_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("t6_rst_busy",  64'(busy),       64'd0);
    chk("t6_rst_data",  64'(m_data),     64'd0);
    chk("t6_rst_keep",  64'(m_keep),     64'd0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    waited = 0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      tick();
      if (m_valid) begin
        seen = 1'b1;
        waited = i;
      end
    end
    chk("t6_latency", 64'(waited), 64'd6);
    chk("t6_data", 64'(m_data), 64'h67666564);
    chk("t6_keep", 64'(m_keep), 64'hF);
    tick();
    chk("t6_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
